key_event_queue: RTL and testbench

Sits directly downstream of the per-key push-button stages. It collects their single-cycle short-press and long-press pulses for N_KEYS keys, serialises same-cycle events, and buffers them in a small first-word-fall-through FIFO. The game-logic FSM pops events through a valid/ready handshake, so no press is lost while the game logic is busy.

---
 rtl/bnw_pkg.sv | 20 ++
 rtl/key_event_fifo.sv | 69 ++++++
 rtl/key_event_queue.sv | 119 +++++++++++
 tb/tb_key_event_queue.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/bnw_pkg.sv
// Purpose: shared event encoding for the key event path (field positions, widths).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bnw_pkg;

    // An event is {key, long}: bit 0 = long press, bits KW:1 = key index.
    localparam int EV_LONG_BIT = 0;
    localparam int EV_KEY_LSB  = 1;

    // Widths for the default 4-key keyboard.
    localparam int DEF_N_KEYS = 4;
    localparam int KW         = $clog2(DEF_N_KEYS);
    localparam int EV_W       = KW + 1;

    // Event width for an arbitrary key-index width.
    function automatic int ev_width(input int kw);
        return kw + 1;
    endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Purpose: generic synchronous first-word-fall-through FIFO with occupancy count.
// Latency: a push is visible at pop_dat one cycle later; the head is combinational from registers.
// Backpressure: a push is accepted when not full or when popping in the same cycle; a pop while empty is ignored.
module key_event_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hold_dat;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign count   = cnt;

    // When empty, keep presenting the last head so the output does not show stale slots.
    assign pop_dat = empty ? hold_dat : mem[rd_ptr];

    // Storage write; no reset needed since slots are only read once written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks occupancy; hold_dat remembers the popped head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            hold_dat <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr   <= rd_ptr + 1'b1;
                hold_dat <= mem[rd_ptr];
            end
            if (push_ok && !pop_ok) begin
                cnt <= cnt + 1'b1;
            end else if (pop_ok && !push_ok) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_event_queue.sv
// Purpose: collect per-key short/long press pulses, serialise them by priority and queue them for the game FSM.
// Latency: pulse in cycle t -> pending at edge t+1 -> queued at edge t+2 (ev_valid in cycle t+2 when idle).
// Backpressure: ev_valid/ev_ready pop; when full, pending bits are held and only a repeat pulse is dropped (sticky overflow).
module key_event_queue
    import bnw_pkg::*;
#(
    parameter int N_KEYS = 4,
    parameter int DEPTH  = 8,
    localparam int KW    = $clog2(N_KEYS),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk_100,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] sh_press,
    input  logic [N_KEYS-1:0] ln_press,
    input  logic              ev_ready,
    input  logic              clr_ovf,
    output logic              ev_valid,
    output logic [KW-1:0]     ev_key,
    output logic              ev_long,
    output logic [CW-1:0]     ev_count,
    output logic              overflow
);

    localparam int Q_EV_W = ev_width(KW);
    localparam int NS     = 2 * N_KEYS;

    // Pending bits interleaved as index 2k = key k short, 2k+1 = key k long.
    // That index is exactly the event encoding {key, long}, and ascending index is the scan priority.
    logic [N_KEYS-1:0] pend_sh;
    logic [N_KEYS-1:0] pend_ln;
    logic [NS-1:0]     pend_all;
    logic [NS-1:0]     new_all;
    logic [NS-1:0]     clr_vec;
    logic [NS-1:0]     drop_vec;
    logic [NS-1:0]     pend_nxt;
    logic [Q_EV_W-1:0] sel_idx;
    logic              sel_any;
    logic              xfer;
    logic              pop_fire;
    logic              fifo_full;
    logic              fifo_empty;
    logic [Q_EV_W-1:0] head_dat;

    // Interleave short/long pending and incoming pulses into scan order.
    always_comb begin
        pend_all = '0;
        new_all  = '0;
        for (int k = 0; k < N_KEYS; k++) begin
            pend_all[2*k]     = pend_sh[k];
            pend_all[2*k + 1] = pend_ln[k];
            new_all[2*k]      = sh_press[k];
            new_all[2*k + 1]  = ln_press[k];
        end
    end

    // Priority selector: lowest set index wins.
    always_comb begin
        sel_idx = '0;
        sel_any = 1'b0;
        for (int i = NS - 1; i >= 0; i--) begin
            if (pend_all[i]) begin
                sel_idx = i[Q_EV_W-1:0];
                sel_any = 1'b1;
            end
        end
    end

    assign pop_fire = ev_valid && ev_ready;
    assign xfer     = sel_any && (!fifo_full || pop_fire);
    assign clr_vec  = xfer ? (NS'(1) << sel_idx) : '0;
    // A pulse on a bit that stays pending this cycle has nowhere to go.
    assign drop_vec = new_all & pend_all & ~clr_vec;
    assign pend_nxt = (pend_all & ~clr_vec) | new_all;

    // Pending registers: set by pulses, cleared when moved into the FIFO.
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            pend_sh <= '0;
            pend_ln <= '0;
        end else begin
            for (int k = 0; k < N_KEYS; k++) begin
                pend_sh[k] <= pend_nxt[2*k];
                pend_ln[k] <= pend_nxt[2*k + 1];
            end
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (|drop_vec) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    key_event_fifo #(
        .WIDTH (Q_EV_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk_100),
        .rst_n    (rst_n),
        .push     (xfer),
        .push_dat (sel_idx),
        .pop      (ev_ready),
        .pop_dat  (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (ev_count)
    );

    assign ev_valid = !fifo_empty;
    assign ev_key   = head_dat[Q_EV_W-1:EV_KEY_LSB];
    assign ev_long  = head_dat[EV_LONG_BIT];

endmodule

// File: tb/tb_key_event_queue.sv
module tb_key_event_queue;

    localparam int N  = 4;
    localparam int D  = 8;
    localparam int KW = 2;
    localparam int CW = 4;

    logic          clk_100 = 1'b0;
    logic          rst_n;
    logic [N-1:0]  sh_press;
    logic [N-1:0]  ln_press;
    logic          ev_ready;
    logic          clr_ovf;
    logic          ev_valid;
    logic [KW-1:0] ev_key;
    logic          ev_long;
    logic [CW-1:0] ev_count;
    logic          overflow;

    always #5 clk_100 = ~clk_100;

    key_event_queue #(.N_KEYS(N), .DEPTH(D)) dut (
        .clk_100  (clk_100),
        .rst_n    (rst_n),
        .sh_press (sh_press),
        .ln_press (ln_press),
        .ev_ready (ev_ready),
        .clr_ovf  (clr_ovf),
        .ev_valid (ev_valid),
        .ev_key   (ev_key),
        .ev_long  (ev_long),
        .ev_count (ev_count),
        .overflow (overflow)
    );

    typedef struct {
        logic [N-1:0]  sh;
        logic [N-1:0]  ln;
        logic          rdy;
        logic          clr;
        logic          vld;
        logic [KW-1:0] key;
        logic          lng;
        logic [CW-1:0] cnt;
        logic          ovf;
    } vec_t;

    typedef struct {
        logic [KW-1:0] key;
        logic          lng;
        int            stamp;
    } exp_t;

    vec_t tbl[12];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   sb_on    = 0;
    bit   lat_on   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic sb_push(input int key, input bit lng);
        exp_t e;
        e.key   = key[KW-1:0];
        e.lng   = lng;
        e.stamp = cyc;
        sb.push_back(e);
    endtask

    // One clock: compare any pop against the scoreboard, then advance past the edge.
    task automatic step();
        exp_t e;
        if (sb_on && ev_valid && ev_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected_pop: got key %0d long %0d, expected no event", ev_key, ev_long);
            end else begin
                e = sb.pop_front();
                chk("sb_key", 32'(ev_key), 32'(e.key));
                chk("sb_long", 32'(ev_long), 32'(e.lng));
                if (lat_on) chk("sb_latency", 32'(cyc - e.stamp), 32'd2);
            end
        end
        @(posedge clk_100);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        sh_press = '0;
        ln_press = '0;
        clr_ovf  = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        // Table: single event, then simultaneous events and their pop order.
        tbl[0]  = '{4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'd0, 1'b0};
        tbl[1]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 4'd1, 1'b0};
        tbl[2]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 4'd1, 1'b0};
        tbl[3]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 4'd0, 1'b0};
        tbl[4]  = '{4'b1001, 4'b0001, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 4'd0, 1'b0};
        tbl[5]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 4'd1, 1'b0};
        tbl[6]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 4'd2, 1'b0};
        tbl[7]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 4'd3, 1'b0};
        tbl[8]  = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 4'd3, 1'b0};
        tbl[9]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 4'd2, 1'b0};
        tbl[10] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 4'd1, 1'b0};
        tbl[11] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 4'd0, 1'b0};

        rst_n    = 1'b0;
        sh_press = '0;
        ln_press = '0;
        ev_ready = 1'b0;
        clr_ovf  = 1'b0;
        #12;
        chk("rst_valid", 32'(ev_valid), 32'd0);
        chk("rst_count", 32'(ev_count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_key", 32'(ev_key), 32'd0);
        chk("rst_long", 32'(ev_long), 32'd0);
        rst_n = 1'b1;
        @(posedge clk_100);
        #1;

        for (int i = 0; i < 12; i++) begin
            sh_press = tbl[i].sh;
            ln_press = tbl[i].ln;
            ev_ready = tbl[i].rdy;
            clr_ovf  = tbl[i].clr;
            step();
            chk($sformatf("tbl%0d_valid", i), 32'(ev_valid), 32'(tbl[i].vld));
            chk($sformatf("tbl%0d_key", i), 32'(ev_key), 32'(tbl[i].key));
            chk($sformatf("tbl%0d_long", i), 32'(ev_long), 32'(tbl[i].lng));
            chk($sformatf("tbl%0d_count", i), 32'(ev_count), 32'(tbl[i].cnt));
            chk($sformatf("tbl%0d_ovf", i), 32'(overflow), 32'(tbl[i].ovf));
        end

        // Full FIFO: eight events queued, one more is held pending until a pop.
        sb_on    = 1;
        ev_ready = 1'b0;
        sh_press = 4'b1111;
        ln_press = 4'b1111;
        for (int k = 0; k < N; k++) begin
            sb_push(k, 1'b0);
            sb_push(k, 1'b1);
        end
        step();
        idle(9);
        chk("full_count", 32'(ev_count), 32'd8);
        ln_press = 4'b0010;
        step();
        idle(3);
        chk("full_held_count", 32'(ev_count), 32'd8);
        chk("full_held_ovf", 32'(overflow), 32'd0);
        sb_push(1, 1'b1);
        ev_ready = 1'b1;
        step();
        ev_ready = 1'b0;
        chk("full_refill_count", 32'(ev_count), 32'd8);
        chk("full_refill_ovf", 32'(overflow), 32'd0);

        // Overflow: repeat pulse on a held pending bit, clear vs set priority.
        sh_press = 4'b0100;
        step();
        sh_press = 4'b0000;
        step();
        chk("ovf_pend_only", 32'(overflow), 32'd0);
        sh_press = 4'b0100;
        step();
        chk("ovf_drop", 32'(overflow), 32'd1);
        chk("ovf_drop_count", 32'(ev_count), 32'd8);
        sh_press = 4'b0100;
        clr_ovf  = 1'b1;
        step();
        chk("ovf_set_wins", 32'(overflow), 32'd1);
        sh_press = 4'b0000;
        clr_ovf  = 1'b1;
        step();
        chk("ovf_cleared", 32'(overflow), 32'd0);
        clr_ovf = 1'b0;
        sb_push(2, 1'b0);
        ev_ready = 1'b1;
        for (int k = 0; k < 30 && (sb.size() != 0 || ev_valid); k++) step();
        chk("drain_sb_empty", 32'(sb.size()), 32'd0);
        chk("drain_count", 32'(ev_count), 32'd0);

        // Streaming with wrap: one pulse per cycle, continuous ready.
        lat_on   = 1;
        ev_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            sh_press = '0;
            ln_press = '0;
            if (((i / 4) % 2) == 0) sh_press[i % 4] = 1'b1;
            else                    ln_press[i % 4] = 1'b1;
            sb_push(i % 4, ((i / 4) % 2) == 1);
            step();
            chk("stream_count_le1", 32'(ev_count <= 1), 32'd1);
        end
        idle(4);
        chk("stream_sb_empty", 32'(sb.size()), 32'd0);
        chk("stream_ovf", 32'(overflow), 32'd0);
        chk("stream_valid_end", 32'(ev_valid), 32'd0);

        // Reset mid-operation: three queued entries and overflow set, cleared without a clock edge.
        sb_on    = 0;
        lat_on   = 0;
        ev_ready = 1'b0;
        sh_press = 4'b0111;
        step();
        sh_press = 4'b0100;
        step();
        idle(4);
        chk("pre_rst_count", 32'(ev_count), 32'd3);
        chk("pre_rst_ovf", 32'(overflow), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(ev_valid), 32'd0);
        chk("mid_rst_count", 32'(ev_count), 32'd0);
        chk("mid_rst_ovf", 32'(overflow), 32'd0);
        #1;
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
